// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, NOP encoding, instruction window size
// and the fetch FSM state encoding.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
   localparam logic [31:0] IMEM_SPAN        = 32'h0000_3000;

   typedef enum logic {
      FETCH_REQ  = 1'b0,
      FETCH_WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction/PC holding register feeding the F/D boundary.
// F_adel storage exists only when FETCH_ALIGN_CHECK_EN is defined.
module fetch_buf
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              consume,
   input  logic [31:0]       load_instr,
   input  logic [ADDR_W-1:0] load_pc,
`ifdef FETCH_ALIGN_CHECK_EN
   input  logic              load_adel,
   output logic              adel,
`endif
   output logic              valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus8
);

   logic [31:0] instr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid    <= 1'b0;
         instr_q  <= INSTR_NOP;
         pc       <= '0;
         pc_plus8 <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         adel     <= 1'b0;
`endif
      end else if (load) begin
         // A load wins over a same-cycle consume: the old entry leaves, the new one stays.
         valid    <= 1'b1;
         instr_q  <= load_instr;
         pc       <= load_pc;
         pc_plus8 <= load_pc + ADDR_W'(8);
`ifdef FETCH_ALIGN_CHECK_EN
         adel     <= load_adel;
`endif
      end else if (consume) begin
         valid    <= 1'b0;
      end
   end

   assign instr = valid ? instr_q : INSTR_NOP;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, req/gnt/rvalid issue FSM, delay-slot redirects.
// Optional FETCH_ALIGN_CHECK_EN adds F_adel and suppresses bad-address requests.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              FD_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_src_pc,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic              F_adel,
`endif
   output logic              F_valid,
   output logic [31:0]       F_instr,
   output logic [ADDR_W-1:0] F_PC,
   output logic [ADDR_W-1:0] F_PCplus8
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic [ADDR_W-1:0] pend_target;
   logic              pend_valid;

   logic [ADDR_W-1:0] ds;
   logic              ds_open;
   logic              block;
   logic              issue_ok;
   logic              pc_bad;
   logic              grant;
   logic              fault;
   logic              advance;
   logic              resp;
   logic              buf_load;

   assign ds       = redirect_src_pc + ADDR_W'(4);
   assign ds_open  = redirect_valid && (pc == ds);
   assign block    = redirect_valid && (pc == ds + ADDR_W'(4));
   assign issue_ok = !reset && (state == FETCH_REQ) && (!F_valid || FD_en) && !block;

`ifdef FETCH_ALIGN_CHECK_EN
   assign pc_bad = (pc[1:0] != 2'b00) || (pc < RESET_PC) ||
                   (pc >= RESET_PC + ADDR_W'(IMEM_SPAN));
`else
   assign pc_bad = 1'b0;
`endif

   assign imem_req  = issue_ok && !pc_bad;
   assign imem_addr = pc;
   assign grant     = imem_req && imem_gnt;
   // A bad PC is retired straight into the buffer as if it had been granted and answered.
   assign fault     = issue_ok && pc_bad;
   assign advance   = grant || fault;
   assign resp      = (state == FETCH_WAIT) && imem_rvalid;
   assign buf_load  = resp || fault;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH_REQ;
         pc          <= RESET_PC;
         inflight_pc <= '0;
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else begin
         if (grant) begin
            state       <= FETCH_WAIT;
            inflight_pc <= pc;
         end else if (resp) begin
            state <= FETCH_REQ;
         end

         if (advance) begin
            pend_valid <= 1'b0;
            if (ds_open)
               pc <= redirect_pc;
            else if (pend_valid)
               pc <= pend_target;
            else
               pc <= pc + ADDR_W'(4);
         end else if (ds_open) begin
            pend_valid  <= 1'b1;
            pend_target <= redirect_pc;
         end else if (block) begin
            pc <= redirect_pc;
         end
      end
   end

   // A redirect must arrive while the delay slot is the next or the just-issued fetch.
   always_ff @(posedge clk) begin
      if (!reset && redirect_valid)
         assert (pc == ds || pc == ds + ADDR_W'(4));
   end

   fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .load       (buf_load),
      .consume    (F_valid && FD_en),
      .load_instr (resp ? imem_rdata : INSTR_NOP),
      .load_pc    (resp ? inflight_pc : pc),
`ifdef FETCH_ALIGN_CHECK_EN
      .load_adel  (fault),
      .adel       (F_adel),
`endif
      .valid      (F_valid),
      .instr      (F_instr),
      .pc         (F_PC),
      .pc_plus8   (F_PCplus8)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays instruction memory and the
// D stage, and predicts the fetch stream from program-order rules.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam logic [31:0] RST_PC = RESET_PC_DEFAULT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        FD_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_src_pc = '0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        F_valid;
   logic [31:0] F_instr;
   logic [31:0] F_PC;
   logic [31:0] F_PCplus8;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        F_adel;
`endif

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .FD_en           (FD_en),
      .redirect_valid  (redirect_valid),
      .redirect_src_pc (redirect_src_pc),
      .redirect_pc     (redirect_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
`ifdef FETCH_ALIGN_CHECK_EN
      .F_adel          (F_adel),
`endif
      .F_valid         (F_valid),
      .F_instr         (F_instr),
      .F_PC            (F_PC),
      .F_PCplus8       (F_PCplus8)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: program-order fetch stream plus one-deep memory and buffer.
   logic [31:0] exp_next;
   logic [31:0] inflight;
   logic [31:0] exp_q[$];
   bit          outstanding;
   bit          buffered;
   bit          br_pend;
   bit          ds_granted;
   bit          next_is_ds;
   bit          redir_sched;
   logic [31:0] br_src;
   logic [31:0] br_tgt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_next    = RST_PC;
      outstanding = 0;
      buffered    = 0;
      exp_q.delete();
      br_pend     = 0;
      ds_granted  = 0;
      next_is_ds  = 0;
      redir_sched = 0;
   endtask

   // Entered and left at posedge+1; holds reset across one clock edge.
   task automatic do_reset();
      reset = 1'b1;
      FD_en = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      redirect_valid = 1'b0;
      #3;
      check("req_in_reset", {31'b0, imem_req}, 32'd0);
      @(posedge clk); #1;
      check("rst_F_valid", {31'b0, F_valid}, 32'd0);
      check("rst_F_instr", F_instr, INSTR_NOP);
      check("rst_F_PC", F_PC, 32'd0);
      check("rst_F_PCplus8", F_PCplus8, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("rst_F_adel", {31'b0, F_adel}, 32'd0);
`endif
      reset = 1'b0;
      model_reset();
   endtask

   // One clock: drive at posedge+1, check and advance model at posedge+4.
   task automatic run_cycle(input int p_fd, input int p_gnt, input int p_rv, input int p_br);
      bit          grant, consume, load, exp_req;
      logic [31:0] a;
      FD_en          = ($urandom_range(0, 99) < p_fd);
      imem_gnt       = ($urandom_range(0, 99) < p_gnt);
      imem_rvalid    = outstanding && ($urandom_range(0, 99) < p_rv);
      imem_rdata     = imem_rvalid ? mem_word(inflight) : $urandom;
      redirect_valid = redir_sched;
      redirect_src_pc = br_src;
      redirect_pc    = br_tgt;
      #3;
      exp_req = !outstanding && (!buffered || FD_en) && !(redir_sched && ds_granted);
      redir_sched = 0;
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      check("F_valid", {31'b0, F_valid}, {31'b0, buffered});
      if (!F_valid) check("F_instr_idle", F_instr, INSTR_NOP);
      grant   = imem_req && imem_gnt;
      consume = F_valid && FD_en;
      load    = imem_rvalid && outstanding;

      if (consume) begin
         if (exp_q.size() == 0) begin
            check("consume_empty", F_PC, 32'hxxxx_xxxx);
            a = F_PC;
         end else begin
            a = exp_q.pop_front();
            check("F_PC", F_PC, a);
            check("F_instr", F_instr, mem_word(a));
            check("F_PCplus8", F_PCplus8, a + 32'd8);
`ifdef FETCH_ALIGN_CHECK_EN
            check("F_adel", {31'b0, F_adel}, 32'd0);
`endif
         end
         if (next_is_ds) begin
            next_is_ds = 0;
         end else if ($urandom_range(0, 99) < p_br) begin
            br_src      = a;
            br_tgt      = RST_PC + 32'($urandom_range(0, 2047)) * 32'd4;
            br_pend     = 1;
            ds_granted  = 0;
            next_is_ds  = 1;
            redir_sched = 1;
         end
      end

      if (load) begin
         exp_q.push_back(inflight);
         outstanding = 0;
         buffered    = 1;
      end else if (consume) begin
         buffered = 0;
      end

      if (grant) begin
         check("imem_addr", imem_addr, exp_next);
         inflight    = exp_next;
         outstanding = 1;
         if (br_pend && exp_next == br_src + 32'd4) begin
            exp_next   = br_tgt;
            br_pend    = 0;
            ds_granted = 1;
         end else begin
            exp_next = exp_next + 32'd4;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      model_reset();
      br_src = '0;
      br_tgt = '0;
      inflight = '0;
      @(posedge clk); #1;
      do_reset();

      // Full-speed sequential fetch.
      repeat (20) run_cycle(100, 100, 100, 0);
      // Stall with the buffer full, then release.
      repeat (6) run_cycle(0, 100, 100, 0);
      repeat (4) run_cycle(100, 100, 100, 0);
      // Random handshakes, stalls and branches.
      repeat (1500) run_cycle(70, 40, 40, 30);
      // Slow grant/response with frequent branches.
      repeat (300) run_cycle(100, 25, 35, 40);
      // Reset while a request is outstanding.
      repeat (4) run_cycle(100, 100, 0, 0);
      do_reset();
      repeat (20) run_cycle(100, 100, 100, 0);
      repeat (400) run_cycle(60, 60, 60, 25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline and the producer side of the F/D boundary.
- Owns the PC register and issues word requests to instruction memory over a req/gnt/rvalid handshake, with one request outstanding at most.
- Buffers the returned word and presents F_instr/F_PC/F_PCplus8 with F_valid to the F/D pipeline register, which consumes them when FD_en=1.
- Applies D-stage branch/jump redirects with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded at reset.
- ADDR_W, 32, PC/address width; all PC arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- FD_en  in  1  F/D register accepts F_* this cycle (0 = stall).
- redirect_valid  in  1  one-cycle pulse; control transfer resolved in D.
- redirect_src_pc  in  ADDR_W  PC of the branch/jump in D.
- redirect_pc  in  ADDR_W  target address.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request word address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- F_valid  out  1  buffer holds an instruction.
- F_instr  out  32  instruction; 32'h0 when F_valid=0.
- F_PC  out  ADDR_W  address of F_instr.
- F_PCplus8  out  ADDR_W  F_PC+8.

Behaviour:
- Reset values:
  - pc=RESET_PC.
  - state=REQ.
  - buf_valid=0; F_instr, F_PC and F_PCplus8 are 0.
  - pend_valid=0; imem_req is 0 in the reset cycle.
- States:
  - REQ: imem_req may be asserted.
  - WAIT: one request outstanding; imem_req=0.
- Issue rule: in REQ, imem_req=1 when (!buf_valid || FD_en) && !block. imem_addr=pc.
- Grant handling:
  - imem_req && imem_gnt: record inflight_pc=pc and go to WAIT.
  - pc <= pend_valid ? pend_target : pc+4.
  - If pend_valid, clear it on this grant.
- Response handling:
  - In WAIT with imem_rvalid: buf <= {imem_rdata, inflight_pc, inflight_pc+8}, buf_valid <= 1, go to REQ.
  - imem_rvalid outside WAIT is ignored.
- Consume: F_valid && FD_en clears buf_valid, unless the same cycle loads a response.
- Buffer occupancy: the issue rule guarantees the buffer is empty or draining whenever a response arrives, so no overflow path exists.
- Latency: grant at cycle N, rvalid at N+k, F_valid=1 at N+k+1. Back-to-back throughput is one instruction per 2 cycles when k=1.
- Redirect, evaluated in the cycle of redirect_valid. Let ds = redirect_src_pc+4:
  - Delay slot not yet granted (pc==ds): set pend_valid and pend_target=redirect_pc. The grant of ds loads pc with the target.
  - Delay slot already granted (pc==ds+4): block=1, so imem_req=0 this cycle, and pc <= redirect_pc at the clock edge.
  - Any other pc value is a protocol violation; assertion only.
- The delay-slot instruction (in flight or buffered) is always delivered; no instruction is squashed.
- redirect_valid and imem_gnt for ds in the same cycle: the grant proceeds for ds and pc <= redirect_pc directly.
- Reset mid-operation: all state returns to reset values. Instruction memory is reset in the same cycle, and any in-flight response is discarded.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - Adds output F_adel (1 bit, reset 0) and a check on every PC that reaches imem_addr.
  - pc[1:0]!=0 or pc outside [RESET_PC, RESET_PC+0x3000): no request is issued.
  - Instead the buffer is loaded directly with F_instr=0 and F_adel=1.
- Not defined: no F_adel port; every PC is requested unchecked.

Decomposition:
- Shared package cpu_pkg holds: RESET_PC default, INSTR_NOP (32'h0), and the fetch state encoding (FETCH_REQ, FETCH_WAIT).
- One natural sub-module: fetch_buf, the one-entry instruction/PC holding register with load/consume/reset. The PC/FSM logic stays in fetch_unit.

Test Plan:
- Reset, gnt and rvalid tied high, FD_en=1: imem_addr sequence 0x3000, 0x3004, 0x3008; F_PC follows it; F_PCplus8=F_PC+8; first F_valid 2 cycles after reset release.
- FD_en=0 for 5 cycles with buffer full: imem_req=0 throughout, F_* stable; on FD_en=1, a request issues that same cycle.
- gnt delayed 3 cycles and rvalid delayed 2 cycles: imem_addr is held stable while ungranted; no duplicate request; F_instr equals the returned word.
- Redirect src=0x3010 and target=0x3100 while pc=0x3014 ungranted: next grants are 0x3014 then 0x3100. Repeat with pc=0x3018: 0x3018 never issued, next grant is 0x3100.
- Reset asserted while in WAIT: next cycle F_valid=0 and F_instr=0; first request after release is 0x3000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x3102: F_adel=1, F_instr=0, F_PC=0x3102, and no imem_req for that address.
